// File: rtl/axi_mem_master_bridge_if.sv
// Bus bundle for the memory-port to AXI4 master bridge: the core-side
// request/response port plus the five AXI4 channels, single-beat use only.
interface axi_mem_master_bridge_if #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_DATA_WIDTH / 8
);
  // core-side memory port
  logic                          req_i;
  logic                          we_i;
  logic [AXI4_ADDRESS_WIDTH-1:0] addr_i;
  logic [AXI4_DATA_WIDTH-1:0]    wdata_i;
  logic [AXI_NUMBYTES-1:0]       be_i;
  logic                          gnt_o;
  logic                          rvalid_o;
  logic [AXI4_DATA_WIDTH-1:0]    rdata_o;
  logic                          err_o;

  // write address channel
  logic [AXI4_ID_WIDTH-1:0]      AWID_o;
  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_o;
  logic [7:0]                    AWLEN_o;
  logic [2:0]                    AWSIZE_o;
  logic [1:0]                    AWBURST_o;
  logic                          AWLOCK_o;
  logic [3:0]                    AWCACHE_o;
  logic [2:0]                    AWPROT_o;
  logic [3:0]                    AWREGION_o;
  logic [AXI4_USER_WIDTH-1:0]    AWUSER_o;
  logic [3:0]                    AWQOS_o;
  logic                          AWVALID_o;
  logic                          AWREADY_i;

  // write data channel
  logic [AXI4_DATA_WIDTH-1:0]    WDATA_o;
  logic [AXI_NUMBYTES-1:0]       WSTRB_o;
  logic                          WLAST_o;
  logic [AXI4_USER_WIDTH-1:0]    WUSER_o;
  logic                          WVALID_o;
  logic                          WREADY_i;

  // write response channel
  logic [AXI4_ID_WIDTH-1:0]      BID_i;
  logic [1:0]                    BRESP_i;
  logic [AXI4_USER_WIDTH-1:0]    BUSER_i;
  logic                          BVALID_i;
  logic                          BREADY_o;

  // read address channel
  logic [AXI4_ID_WIDTH-1:0]      ARID_o;
  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_o;
  logic [7:0]                    ARLEN_o;
  logic [2:0]                    ARSIZE_o;
  logic [1:0]                    ARBURST_o;
  logic                          ARLOCK_o;
  logic [3:0]                    ARCACHE_o;
  logic [2:0]                    ARPROT_o;
  logic [3:0]                    ARREGION_o;
  logic [AXI4_USER_WIDTH-1:0]    ARUSER_o;
  logic [3:0]                    ARQOS_o;
  logic                          ARVALID_o;
  logic                          ARREADY_i;

  // read data channel
  logic [AXI4_ID_WIDTH-1:0]      RID_i;
  logic [AXI4_DATA_WIDTH-1:0]    RDATA_i;
  logic [1:0]                    RRESP_i;
  logic                          RLAST_i;
  logic [AXI4_USER_WIDTH-1:0]    RUSER_i;
  logic                          RVALID_i;
  logic                          RREADY_o;

  // the bridge itself
  modport master (
    input  req_i, we_i, addr_i, wdata_i, be_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output AWID_o, AWADDR_o, AWLEN_o, AWSIZE_o, AWBURST_o, AWLOCK_o, AWCACHE_o,
           AWPROT_o, AWREGION_o, AWUSER_o, AWQOS_o, AWVALID_o,
    input  AWREADY_i,
    output WDATA_o, WSTRB_o, WLAST_o, WUSER_o, WVALID_o,
    input  WREADY_i,
    input  BID_i, BRESP_i, BUSER_i, BVALID_i,
    output BREADY_o,
    output ARID_o, ARADDR_o, ARLEN_o, ARSIZE_o, ARBURST_o, ARLOCK_o, ARCACHE_o,
           ARPROT_o, ARREGION_o, ARUSER_o, ARQOS_o, ARVALID_o,
    input  ARREADY_i,
    input  RID_i, RDATA_i, RRESP_i, RLAST_i, RUSER_i, RVALID_i,
    output RREADY_o
  );

  // the environment: core on one side, AXI slave/interconnect on the other
  modport slave (
    output req_i, we_i, addr_i, wdata_i, be_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  AWID_o, AWADDR_o, AWLEN_o, AWSIZE_o, AWBURST_o, AWLOCK_o, AWCACHE_o,
           AWPROT_o, AWREGION_o, AWUSER_o, AWQOS_o, AWVALID_o,
    output AWREADY_i,
    input  WDATA_o, WSTRB_o, WLAST_o, WUSER_o, WVALID_o,
    output WREADY_i,
    output BID_i, BRESP_i, BUSER_i, BVALID_i,
    input  BREADY_o,
    input  ARID_o, ARADDR_o, ARLEN_o, ARSIZE_o, ARBURST_o, ARLOCK_o, ARCACHE_o,
           ARPROT_o, ARREGION_o, ARUSER_o, ARQOS_o, ARVALID_o,
    output ARREADY_i,
    output RID_i, RDATA_i, RRESP_i, RLAST_i, RUSER_i, RVALID_i,
    input  RREADY_o
  );
endinterface

// File: rtl/axi_mem_master_bridge.sv
// Memory-port to AXI4 master bridge. Each accepted core request becomes one
// single-beat AXI4 read or write; only one transaction is in flight, and the
// core sees a one-cycle rvalid_o pulse when the AXI response returns.
module axi_mem_master_bridge #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 16,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int AXI_NUMBYTES       = AXI4_DATA_WIDTH / 8,
  parameter int AXI_ID_VALUE       = 0
) (
  input  logic ACLK,
  input  logic ARESETn,
  axi_mem_master_bridge_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;

  localparam logic [2:0]               AXSIZE = 3'($clog2(AXI_NUMBYTES));
  localparam logic [AXI4_ID_WIDTH-1:0] AXID   = AXI4_ID_WIDTH'(AXI_ID_VALUE);

  logic [2:0]                    state_reg;
  logic [AXI4_ADDRESS_WIDTH-1:0] addr_reg;
  logic [AXI4_DATA_WIDTH-1:0]    wdata_reg;
  logic [AXI_NUMBYTES-1:0]       be_reg;
  logic                          awvalid_reg;
  logic                          wvalid_reg;
  logic                          arvalid_reg;
  logic                          rvalid_reg;
  logic [AXI4_DATA_WIDTH-1:0]    rdata_reg;
  logic                          err_reg;

  logic gnt;
  logic aw_hs;
  logic w_hs;
  logic aw_done;
  logic w_done;

  // IDs, last flags, user fields and the low response bit carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{bus.BID_i, bus.BUSER_i, bus.BRESP_i[0],
                           bus.RID_i, bus.RUSER_i, bus.RRESP_i[0], bus.RLAST_i};

  // grant and channel-completion terms; a channel counts as done once its
  // VALID has dropped or it is handshaking in this very cycle
  always_comb begin
    gnt     = ARESETn & (state_reg == ST_IDLE) & bus.req_i;
    aw_hs   = awvalid_reg & bus.AWREADY_i;
    w_hs    = wvalid_reg & bus.WREADY_i;
    aw_done = ~awvalid_reg | bus.AWREADY_i;
    w_done  = ~wvalid_reg | bus.WREADY_i;
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_reg;
  assign bus.rdata_o  = rdata_reg;
  assign bus.err_o    = err_reg;

  // READY terms are also masked by reset so no beat is consumed while aborting
  assign bus.BREADY_o = ARESETn & (state_reg == ST_WRESP);
  assign bus.RREADY_o = ARESETn & (state_reg == ST_RDATA);

  assign bus.AWID_o     = AXID;
  assign bus.AWADDR_o   = addr_reg;
  assign bus.AWLEN_o    = 8'd0;
  assign bus.AWSIZE_o   = AXSIZE;
  assign bus.AWBURST_o  = 2'b01;
  assign bus.AWLOCK_o   = 1'b0;
  assign bus.AWCACHE_o  = 4'd0;
  assign bus.AWPROT_o   = 3'd0;
  assign bus.AWREGION_o = 4'd0;
  assign bus.AWUSER_o   = '0;
  assign bus.AWQOS_o    = 4'd0;
  assign bus.AWVALID_o  = awvalid_reg;

  assign bus.WDATA_o    = wdata_reg;
  assign bus.WSTRB_o    = be_reg;
  assign bus.WLAST_o    = 1'b1;
  assign bus.WUSER_o    = '0;
  assign bus.WVALID_o   = wvalid_reg;

  assign bus.ARID_o     = AXID;
  assign bus.ARADDR_o   = addr_reg;
  assign bus.ARLEN_o    = 8'd0;
  assign bus.ARSIZE_o   = AXSIZE;
  assign bus.ARBURST_o  = 2'b01;
  assign bus.ARLOCK_o   = 1'b0;
  assign bus.ARCACHE_o  = 4'd0;
  assign bus.ARPROT_o   = 3'd0;
  assign bus.ARREGION_o = 4'd0;
  assign bus.ARUSER_o   = '0;
  assign bus.ARQOS_o    = 4'd0;
  assign bus.ARVALID_o  = arvalid_reg;

  // transaction sequencer: accept, drive address/data channels, await response
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      be_reg      <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
    end else begin
      rvalid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (gnt) begin
            addr_reg  <= bus.addr_i;
            wdata_reg <= bus.wdata_i;
            be_reg    <= bus.be_i;
            if (bus.we_i) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= ST_WR;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_RADDR;
            end
          end
        end
        ST_WR: begin
          if (aw_hs) awvalid_reg <= 1'b0;
          if (w_hs)  wvalid_reg  <= 1'b0;
          if (aw_done && w_done) state_reg <= ST_WRESP;
        end
        ST_WRESP: begin
          if (bus.BVALID_i) begin
            rvalid_reg <= 1'b1;
            err_reg    <= bus.BRESP_i[1];
            state_reg  <= ST_IDLE;
          end
        end
        ST_RADDR: begin
          if (bus.ARREADY_i) begin
            arvalid_reg <= 1'b0;
            state_reg   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (bus.RVALID_i) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= bus.RDATA_i;
            err_reg    <= bus.RRESP_i[1];
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_master_bridge.sv
// Directed plus randomized bench for axi_mem_master_bridge. The bench plays
// both the core and a behavioural AXI slave with programmable wait states;
// expectations come from a word-addressed memory model and the latency rules.
module tb_axi_mem_master_bridge;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          d1;    // AW (write) or AR (read) ready delay
    int          d2;    // W ready delay (write) or R valid delay (read)
    int          d3;    // B valid delay (write)
    logic [1:0]  resp;
  } txn_t;

  logic ACLK;
  logic ARESETn;
  int   errors;
  int   checks;
  int   txn_no;
  logic [31:0] last_rdata;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];

  axi_mem_master_bridge_if #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(16), .AXI4_USER_WIDTH(10)
  ) bus ();

  axi_mem_master_bridge #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(16),
    .AXI4_USER_WIDTH(10), .AXI_ID_VALUE(0)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .bus(bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
  endfunction

  task automatic clear_slave();
    bus.AWREADY_i = 1'b0;
    bus.WREADY_i  = 1'b0;
    bus.BVALID_i  = 1'b0;
    bus.BRESP_i   = 2'b00;
    bus.ARREADY_i = 1'b0;
    bus.RVALID_i  = 1'b0;
    bus.RDATA_i   = '0;
    bus.RRESP_i   = 2'b00;
  endtask

  task automatic present(input txn_t t);
    bus.req_i   = 1'b1;
    bus.we_i    = t.we;
    bus.addr_i  = t.addr;
    bus.wdata_i = t.wdata;
    bus.be_i    = t.be;
  endtask

  // Runs one transaction whose request is already on the core port (driven
  // just after a rising edge). Returns just after the completion edge with
  // the next request presented when has_next is set.
  task automatic run_txn(input txn_t t, input bit has_next, input txn_t nx);
    bit aw_done, w_done, b_done, ar_done;
    int bstart, rstart, done_cyc, exp_cyc;
    logic [31:0] exp_rd, cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    bit exp_err;
    aw_done = 0; w_done = 0; b_done = 0; ar_done = 0;
    bstart = 1000; rstart = 1000; done_cyc = -1;
    cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0; cap_araddr = '0;
    exp_err = t.resp[1];
    if (t.we) begin
      exp_rd  = last_rdata;
      exp_cyc = 3 + ((t.d1 > t.d2) ? t.d1 : t.d2) + t.d3;
      if (!exp_err) ref_mem[t.addr] = merge(ref_rd(t.addr), t.wdata, t.be);
    end else begin
      exp_rd  = ref_rd(t.addr);
      exp_cyc = 3 + t.d1 + t.d2;
    end

    @(negedge ACLK);
    chk("gnt", bus.gnt_o, 1);
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(posedge ACLK); #1;
      if (bus.rvalid_o) begin
        done_cyc = c;
      end else begin
        if (c == 1 && !has_next) bus.req_i = 1'b0;
        if (t.we) begin
          chk("arvalid_in_write", bus.ARVALID_o, 0);
          if (!aw_done) begin
            chk("awvalid", bus.AWVALID_o, 1);
            chk("awaddr", bus.AWADDR_o, t.addr);
            chk("awsize", bus.AWSIZE_o, 2);
          end else chk("awvalid_drop", bus.AWVALID_o, 0);
          if (!w_done) begin
            chk("wvalid", bus.WVALID_o, 1);
            chk("wdata", bus.WDATA_o, t.wdata);
            chk("wstrb", bus.WSTRB_o, t.be);
            chk("wlast", bus.WLAST_o, 1);
          end else chk("wvalid_drop", bus.WVALID_o, 0);
          bus.AWREADY_i = !aw_done && (c >= 1 + t.d1);
          bus.WREADY_i  = !w_done && (c >= 1 + t.d2);
          bus.BVALID_i  = aw_done && w_done && !b_done && (c >= bstart + t.d3);
          bus.BRESP_i   = t.resp;
        end else begin
          chk("awvalid_in_read", bus.AWVALID_o, 0);
          if (!ar_done) begin
            chk("arvalid", bus.ARVALID_o, 1);
            chk("araddr", bus.ARADDR_o, t.addr);
            chk("arsize", bus.ARSIZE_o, 2);
            chk("arlen_burst", {bus.ARLEN_o, bus.ARBURST_o}, 10'h001);
          end else chk("arvalid_drop", bus.ARVALID_o, 0);
          bus.ARREADY_i = !ar_done && (c >= 1 + t.d1);
          bus.RVALID_i  = ar_done && (c >= rstart + t.d2);
          bus.RDATA_i   = slv_rd(cap_araddr);
          bus.RRESP_i   = t.resp;
        end
        @(negedge ACLK);
        chk("gnt_busy", bus.gnt_o, 0);
        if (t.we) begin
          chk("bready", bus.BREADY_o, aw_done && w_done);
          chk("rready_in_write", bus.RREADY_o, 0);
          if (bus.AWVALID_o && bus.AWREADY_i) begin aw_done = 1; cap_awaddr = bus.AWADDR_o; end
          if (bus.WVALID_o && bus.WREADY_i) begin
            w_done = 1; cap_wdata = bus.WDATA_o; cap_wstrb = bus.WSTRB_o;
          end
          if (aw_done && w_done && bstart == 1000) bstart = c + 1;
          if (bus.BVALID_i && bus.BREADY_o) begin
            b_done = 1;
            if (!t.resp[1]) slv_mem[cap_awaddr] = merge(slv_rd(cap_awaddr), cap_wdata, cap_wstrb);
          end
        end else begin
          chk("rready", bus.RREADY_o, ar_done);
          chk("bready_in_read", bus.BREADY_o, 0);
          if (bus.ARVALID_o && bus.ARREADY_i) begin
            ar_done = 1; cap_araddr = bus.ARADDR_o; rstart = c + 1;
          end
        end
      end
    end

    chk("latency", done_cyc, exp_cyc);
    chk("rdata", bus.rdata_o, exp_rd);
    chk("err", bus.err_o, exp_err);
    if (!t.we) last_rdata = exp_rd;
    $display("txn %0d %s addr=%h wdata=%h be=%h resp=%0d cycles=%0d rdata=%h err=%0b",
             txn_no, t.we ? "WR" : "RD", t.addr, t.wdata, t.be, t.resp, done_cyc,
             bus.rdata_o, bus.err_o);
    txn_no++;
    clear_slave();
    if (has_next) present(nx);
    else bus.req_i = 1'b0;
  endtask

  function automatic txn_t rand_txn(input bit we);
    txn_t t;
    t.we    = we;
    t.addr  = 32'h400 + 32'(4 * $urandom_range(0, 7));
    t.wdata = $urandom;
    t.be    = 4'($urandom_range(1, 15));
    t.d1    = $urandom_range(0, 3);
    t.d2    = $urandom_range(0, 3);
    t.d3    = $urandom_range(0, 2);
    t.resp  = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
    return t;
  endfunction

  initial begin
    txn_t t, nx;
    txn_t chain [6];
    errors = 0; checks = 0; txn_no = 0; last_rdata = '0;
    ARESETn = 1'b0;
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0;
    bus.BID_i = '0; bus.BUSER_i = '0; bus.RID_i = '0; bus.RLAST_i = 1'b1; bus.RUSER_i = '0;
    clear_slave();

    // reset state; req_i must be ignored while reset is low
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("gnt_in_reset", bus.gnt_o, 0);
    @(posedge ACLK); #1;
    chk("rst_valids", {bus.AWVALID_o, bus.WVALID_o, bus.ARVALID_o, bus.BREADY_o, bus.RREADY_o}, 0);
    chk("rst_rvalid_err", {bus.rvalid_o, bus.err_o}, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_addr", bus.AWADDR_o, 0);
    ARESETn = 1'b1;
    bus.req_i = 1'b0;
    @(negedge ACLK);
    chk("idle_gnt_no_req", bus.gnt_o, 0);

    // zero-wait read of a preloaded word
    ref_mem[32'h1000] = 32'hDEAD_BEEF;
    slv_mem[32'h1000] = 32'hDEAD_BEEF;
    @(posedge ACLK); #1;
    t = '{we:0, addr:32'h1000, wdata:0, be:4'hF, d1:0, d2:0, d3:0, resp:2'b00};
    present(t); run_txn(t, 0, t);

    // write with AWREADY three cycles late, WREADY immediate
    t = '{we:1, addr:32'h20, wdata:32'h1234_5678, be:4'b0110, d1:3, d2:0, d3:0, resp:2'b00};
    present(t); run_txn(t, 0, t);
    // read back the partially written word
    t = '{we:0, addr:32'h20, wdata:0, be:4'hF, d1:1, d2:2, d3:0, resp:2'b00};
    present(t); run_txn(t, 0, t);
    // slave error on a write, then on a read
    t = '{we:1, addr:32'h24, wdata:32'hCAFE_F00D, be:4'hF, d1:0, d2:2, d3:1, resp:2'b10};
    present(t); run_txn(t, 0, t);
    t = '{we:0, addr:32'h24, wdata:0, be:4'hF, d1:0, d2:0, d3:0, resp:2'b11};
    present(t); run_txn(t, 0, t);

    // req_i held high back to back with alternating direction
    for (int i = 0; i < 6; i++) chain[i] = rand_txn(i % 2 == 0);
    present(chain[0]);
    for (int i = 0; i < 6; i++) run_txn(chain[i], i < 5, chain[(i < 5) ? i + 1 : i]);

    // randomized mix with idle gaps
    for (int i = 0; i < 24; i++) begin
      t = rand_txn($urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) @(posedge ACLK);
      @(posedge ACLK); #1;
      present(t); run_txn(t, 0, t);
    end

    // reset in RDATA with a response pending: aborted without completion
    @(posedge ACLK); #1;
    t = '{we:0, addr:32'h300, wdata:0, be:4'hF, d1:0, d2:0, d3:0, resp:2'b00};
    present(t);
    @(negedge ACLK);
    chk("rst_case_gnt", bus.gnt_o, 1);
    @(posedge ACLK); #1;
    bus.req_i = 1'b0;
    chk("rst_case_arvalid", bus.ARVALID_o, 1);
    bus.ARREADY_i = 1'b1;
    @(posedge ACLK); #1;
    bus.ARREADY_i = 1'b0;
    bus.RVALID_i = 1'b1; bus.RDATA_i = 32'h5555_AAAA;
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("rst_case_rready_in_reset", bus.RREADY_o, 0);
    @(posedge ACLK); #1;
    chk("rst_case_rvalid", bus.rvalid_o, 0);
    chk("rst_case_rdata", bus.rdata_o, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rst_case_rready_after", bus.RREADY_o, 0);
    @(posedge ACLK); #1;
    chk("rst_case_no_pulse", bus.rvalid_o, 0);
    clear_slave();
    last_rdata = '0;
    t = '{we:0, addr:32'h300, wdata:0, be:4'hF, d1:0, d2:1, d3:0, resp:2'b00};
    present(t); run_txn(t, 0, t);

    // stray B/R beats while idle must not be accepted or reported
    bus.RVALID_i = 1'b1; bus.BVALID_i = 1'b1; bus.RDATA_i = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("idle_rready", bus.RREADY_o, 0);
      chk("idle_bready", bus.BREADY_o, 0);
      @(posedge ACLK); #1;
      chk("idle_rvalid", bus.rvalid_o, 0);
    end
    clear_slave();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
